// File: rtl/alu_result_pipe.sv
// ALU result-select register: picks src0/src1/src2 by opcode into a valid/ready
// output stage, maintains Z/N/V flags and counts illegal opcodes.
//
// Ports:
//   clk, rst_n (sync, active low)
//   in_valid/in_ready, opcode, src0..src2, add_ovf    : execute-side input
//   out_valid/out_ready, out_data, out_opcode          : writeback-side output
//   flag_z/flag_n/flag_v                               : flag register
//   err_sticky, err_count, err_clr                     : illegal-opcode tracking
//
// Build option: define ALU_RESULT_SKID_EN for a 2-entry skid buffer with a
// registered in_ready; otherwise a single output register is used.
module alu_result_pipe #(
  parameter int WIDTH    = 16,
  parameter int OPCODE_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    src0,
  input  logic [WIDTH-1:0]    src1,
  input  logic [WIDTH-1:0]    src2,
  input  logic                add_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_v,
  output logic                err_sticky,
  output logic [CNT_W-1:0]    err_count,
  input  logic                err_clr
);

  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_RED = OPCODE_W'(4'b0011);
  localparam logic [OPCODE_W-1:0] OP_PAD = OPCODE_W'(4'b0111);

  logic             is_addsub;
  logic             is_logic;
  logic             is_pad;
  logic             legal;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             push;
  logic             bad;

  always_comb begin
    is_addsub = (opcode == OP_ADD) || (opcode == OP_SUB);
    is_logic  = (opcode == OP_XOR) || (opcode == OP_RED);
    is_pad    = (opcode == OP_PAD);
    legal     = is_addsub || is_logic || is_pad;
    sel_data  = '0;
    unique case (1'b1)
      is_addsub: sel_data = src0;
      is_logic:  sel_data = src1;
      is_pad:    sel_data = src2;
      default:   sel_data = '0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign bad    = accept && !legal;

  // Flags and error tracking
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             v_q, v_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push) begin
      z_d = (sel_data == '0);
      if (is_addsub) begin
        n_d = sel_data[WIDTH-1];
        v_d = add_ovf;
      end
    end
    // Clear first so a same-cycle illegal accept lands on a fresh count.
    if (err_clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
    if (bad) begin
      sticky_d = 1'b1;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign flag_z     = z_q;
  assign flag_n     = n_q;
  assign flag_v     = v_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

`ifdef ALU_RESULT_SKID_EN
  // Two-entry FIFO: head feeds the output, tail catches the entry that
  // arrives while the head is stalled.
  logic [1:0]          fill_q, fill_d;
  logic [WIDTH-1:0]    hd_q, hd_d;
  logic [OPCODE_W-1:0] ho_q, ho_d;
  logic [WIDTH-1:0]    td_q, td_d;
  logic [OPCODE_W-1:0] to_q, to_d;
  logic                pop;

  assign in_ready = rst_n && (fill_q != 2'd2);
  assign pop      = (fill_q != 2'd0) && out_ready;

  always_comb begin
    fill_d = fill_q;
    hd_d   = hd_q;
    ho_d   = ho_q;
    td_d   = td_q;
    to_d   = to_q;
    unique case (fill_q)
      2'd0: begin
        if (push) begin
          hd_d   = sel_data;
          ho_d   = opcode;
          fill_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          hd_d = sel_data;
          ho_d = opcode;
        end else if (push) begin
          td_d   = sel_data;
          to_d   = opcode;
          fill_d = 2'd2;
        end else if (pop) begin
          fill_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          hd_d   = td_q;
          ho_d   = to_q;
          fill_d = 2'd1;
        end
      end
      default: fill_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q <= 2'd0;
      hd_q   <= '0;
      ho_q   <= '0;
      td_q   <= '0;
      to_q   <= '0;
    end else begin
      fill_q <= fill_d;
      hd_q   <= hd_d;
      ho_q   <= ho_d;
      td_q   <= td_d;
      to_q   <= to_d;
    end
  end

  assign out_valid  = (fill_q != 2'd0);
  assign out_data   = hd_q;
  assign out_opcode = ho_q;
`else
  logic                vld_q, vld_d;
  logic [WIDTH-1:0]    dat_q, dat_d;
  logic [OPCODE_W-1:0] op_q, op_d;

  assign in_ready = rst_n && (!vld_q || out_ready);

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    op_d  = op_q;
    if (vld_q && out_ready) vld_d = 1'b0;
    if (push) begin
      vld_d = 1'b1;
      dat_d = sel_data;
      op_d  = opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
      op_q  <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      op_q  <= op_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_data   = dat_q;
  assign out_opcode = op_q;
`endif

endmodule

// File: tb/tb_alu_result_pipe.sv
// Randomized bench for alu_result_pipe against a queue-based reference model.
// A second instance with CNT_W=2 shares the stimulus to cover counter saturation.
module tb_alu_result_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] src0, src1, src2;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_opcode;
  logic        flag_z, flag_n, flag_v;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic        err_clr;

  logic        s_in_ready, s_out_valid;
  logic [15:0] s_out_data;
  logic [3:0]  s_out_opcode;
  logic        s_z, s_n, s_v, s_sticky;
  logic [1:0]  s_count;

  always #5 clk = ~clk;

  alu_result_pipe #(.WIDTH(16), .OPCODE_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .src0(src0), .src1(src1), .src2(src2),
    .add_ovf(add_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_opcode(out_opcode),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .err_sticky(err_sticky), .err_count(err_count), .err_clr(err_clr)
  );

  alu_result_pipe #(.WIDTH(16), .OPCODE_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode(opcode), .src0(src0), .src1(src1), .src2(src2),
    .add_ovf(add_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_opcode(s_out_opcode),
    .flag_z(s_z), .flag_n(s_n), .flag_v(s_v),
    .err_sticky(s_sticky), .err_count(s_count), .err_clr(err_clr)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  op;
  } ent_t;

`ifdef ALU_RESULT_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  ent_t q[$];
  bit   m_z, m_n, m_v, m_sticky, just_rst;
  int   m_cnt, m_cnt2;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
  endfunction

  // One clock: drive, check pre-edge outputs against the model, advance model.
  task automatic step(input bit rn, input bit iv, input logic [3:0] op,
                      input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input bit ovf,
                      input bit ordy, input bit clr, input bit do_chk);
    bit          e_rdy, acc;
    logic [15:0] sel;
    @(negedge clk);
    rst_n = rn; in_valid = iv; opcode = op;
    src0 = s0; src1 = s1; src2 = s2;
    add_ovf = ovf; out_ready = ordy; err_clr = clr;
    #1;
    if (!rn) e_rdy = 1'b0;
    else if (CAP == 1) e_rdy = (q.size() == 0) || ordy;
    else e_rdy = (q.size() < CAP);
    if (do_chk) begin
      chk("in_ready", in_ready, e_rdy);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_opcode", out_opcode, q[0].op);
      end
      if (just_rst) begin
        chk("rst_data", out_data, 0);
        chk("rst_opcode", out_opcode, 0);
      end
      chk("flag_z", flag_z, m_z);
      chk("flag_n", flag_n, m_n);
      chk("flag_v", flag_v, m_v);
      chk("err_sticky", err_sticky, m_sticky);
      chk("err_count", err_count, m_cnt);
      chk("sat_count", s_count, m_cnt2);
      chk("sat_sticky", s_sticky, m_sticky);
    end
    if (!rn) begin
      q.delete();
      m_z = 0; m_n = 0; m_v = 0; m_sticky = 0;
      m_cnt = 0; m_cnt2 = 0; just_rst = 1;
      return;
    end
    just_rst = 0;
    acc = iv && e_rdy;
    if (q.size() > 0 && ordy) void'(q.pop_front());
    if (clr) begin
      m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
    end
    if (acc && is_legal(op)) begin
      case (op)
        4'd0, 4'd1: sel = s0;
        4'd2, 4'd3: sel = s1;
        default:    sel = s2;
      endcase
      q.push_back('{d: sel, op: op});
      m_z = (sel == 16'h0);
      if (op <= 4'd1) begin
        m_n = sel[15];
        m_v = ovf;
      end
    end else if (acc) begin
      m_sticky = 1;
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b, c;
    // First reset edge brings the DUT out of X; checks begin on the second.
    step(0, 1, 4'd0, 16'h1, 16'h1, 16'h1, 1, 1, 0, 0);
    step(0, 1, 4'd0, 16'h1, 16'h1, 16'h1, 1, 1, 0, 1);
    // ADD 8000 with overflow, then XOR 0
    step(1, 1, 4'd0, 16'h8000, 16'h5, 16'h6, 1, 1, 0, 1);
    step(1, 1, 4'd2, 16'h7, 16'h0, 16'h6, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    // Back-pressure: PADDSB held, RED waits
    step(1, 1, 4'd7, 16'h1, 16'h2, 16'h1234, 0, 0, 0, 1);
    step(1, 1, 4'd3, 16'h1, 16'hbeef, 16'h0, 0, 0, 0, 1);
    step(1, 1, 4'd3, 16'h1, 16'hbeef, 16'h0, 0, 0, 0, 1);
    step(1, 1, 4'd3, 16'h1, 16'hbeef, 16'h0, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    // Illegal x3, then clear with simultaneous illegal
    repeat (3) step(1, 1, 4'b1010, 16'h0, 16'h0, 16'h0, 1, 1, 0, 1);
    step(1, 1, 4'b1111, 16'h0, 16'h0, 16'h0, 0, 1, 1, 1);
    // Five more illegal: CNT_W=2 instance saturates at 3
    repeat (5) step(1, 1, 4'b1100, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    // Skid-style sequence: SUB then XOR under stall, then drain
    step(1, 1, 4'd1, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1);
    step(1, 1, 4'd2, 16'h0, 16'h9, 16'h0, 0, 0, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    step(1, 0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 75) begin
        case ($urandom_range(0, 4))
          0: op = 4'd0;
          1: op = 4'd1;
          2: op = 4'd2;
          3: op = 4'd3;
          default: op = 4'd7;
        endcase
      end else begin
        op = 4'($urandom_range(8, 15));
      end
      a = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      c = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 70, op,
           a, b, c, 1'($urandom), $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 4, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
